// File: rtl/serial_adder_dec_pkg.sv
// Shared types and helpers for the serial decoder-cell adder.
// Imported by the top module; no feature macros are used here.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter width for a beat count; never narrower than one bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                w = i + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/serial_adder_dec_if.sv
// Operand/result handshake bundle for serial_adder_dec.
// Optional SERIAL_ADDER_OVF_EN adds the signed-overflow flag ovf.
interface serial_adder_dec_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout
    );
`endif
endinterface

// File: rtl/serial_adder_dec_fa_dec_cell.sv
// One-bit full adder realised as a 3-to-8 one-hot decoder of {a,b,c}.
// sum ORs minterms 1,2,4,7; carry ORs minterms 3,5,6,7.
module fa_dec_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);
    logic [7:0] dec;

    always_comb begin
        dec = '0;
        dec[{a, b, c}] = 1'b1;
    end

    assign s  = |(dec & 8'b1001_0110);
    assign co = |(dec & 8'b1110_1000);

endmodule

// File: rtl/serial_adder_dec.sv
// Multi-cycle add/subtract: BPC chained decoder FA cells per beat, LSB first.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder_dec
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned BPC   = 1
) (
    input logic              clk,
    input logic              rst_n,
    serial_adder_dec_if.slave bus
);
    localparam int unsigned BEATS = WIDTH / BPC;
    localparam int unsigned CW    = clog2(BEATS);
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    if (WIDTH < 2 || BPC < 1 || (WIDTH % BPC) != 0) begin : g_param_check
        $error("serial_adder_dec: WIDTH must be >= 2 and a multiple of BPC");
    end

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] sum_q;
    logic             carry;
    logic             cout_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [CW-1:0]    cnt;
    logic [BPC:0]     c;
    logic [BPC-1:0]   s;

    assign c[0] = carry;

    for (genvar i = 0; i < BPC; i++) begin : g_cell
        fa_dec_cell u_cell (
            .a  (sa[i]),
            .b  (sb[i]),
            .c  (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    // New sum bits enter at the top so the last beat leaves the result LSB-aligned.
    always_comb begin
        res_next = res >> BPC;
        res_next[WIDTH-1 -: BPC] = s;
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q;
    assign bus.ovf = ovf_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            sa          <= '0;
            sb          <= '0;
            res         <= '0;
            carry       <= 1'b0;
            cnt         <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        sa         <= bus.a;
                        sb         <= bus.sub ? ~bus.b : bus.b;
                        carry      <= bus.sub ? 1'b1 : bus.cin;
                        cnt        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sa    <= sa >> BPC;
                    sb    <= sb >> BPC;
                    res   <= res_next;
                    carry <= c[BPC];
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum_q       <= res_next;
                        cout_q      <= c[BPC];
                        out_valid_q <= 1'b1;
                        state       <= ST_DONE;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf_q       <= c[BPC-1] ^ c[BPC];
`endif
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

endmodule

// File: tb/tb_serial_adder_dec.sv
// Scoreboard bench: one BPC=1 and one BPC=4 instance share stimulus.
// Honours SERIAL_ADDER_OVF_EN when defined (adds ovf checking).
module tb_serial_adder_dec;
    localparam int unsigned W = 8;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        longint       acc;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_ready;

    longint cyc;
    int     vectors;
    int     miscompares;
    int     timeouts;
    int     seen_to;
    exp_t   q[2][$];
    logic   prev_ov[2];
    logic   prev_hs[2];
    longint beats[2];

    serial_adder_dec_if #(.WIDTH(W)) bus1 ();
    serial_adder_dec_if #(.WIDTH(W)) bus4 ();

    assign bus1.in_valid  = in_valid;
    assign bus1.a         = a;
    assign bus1.b         = b;
    assign bus1.cin       = cin;
    assign bus1.sub       = sub;
    assign bus1.out_ready = out_ready;
    assign bus4.in_valid  = in_valid;
    assign bus4.a         = a;
    assign bus4.b         = b;
    assign bus4.cin       = cin;
    assign bus4.sub       = sub;
    assign bus4.out_ready = out_ready;

    serial_adder_dec #(.WIDTH(W), .BPC(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    serial_adder_dec #(.WIDTH(W), .BPC(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic mcin, input logic msub);
        exp_t   e;
        longint ua, ub, sa, sb, full, r;
        ua = longint'(ma);
        ub = longint'(mb);
        sa = ma[W-1] ? ua - (longint'(1) << W) : ua;
        sb = mb[W-1] ? ub - (longint'(1) << W) : ub;
        if (!msub) begin
            full = ua + ub + longint'(mcin);
            e.s  = W'(full);
            e.c  = (full >= (longint'(1) << W));
            r    = sa + sb + longint'(mcin);
        end else begin
            e.s  = W'(ua - ub);
            e.c  = (ua >= ub);
            r    = sa - sb;
        end
        e.o   = (r > (longint'(1) << (W-1)) - 1) || (r < -(longint'(1) << (W-1)));
        e.acc = 0;
        return e;
    endfunction

    task automatic chk(input int p, input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL dut%0d %s: got 0x%0h, expected 0x%0h (cycle %0d)", p, name, act, exp, cyc);
        end
    endtask

    task automatic check_port(input int p, input logic ov, input logic ir,
                              input logic [W-1:0] s, input logic co, input logic of);
        exp_t e;
        if (!rst_n) begin
            chk(p, "reset_state", {ov, ir, co, of}, 4'b0100);
            chk(p, "reset_sum", s, 0);
            q[p].delete();
            prev_ov[p] = 1'b0;
            prev_hs[p] = 1'b0;
            return;
        end
        if (prev_hs[p]) chk(p, "idle_after_pop", {ir, ov}, 2'b10);
        prev_hs[p] = 1'b0;
        if (ov) begin
            if (q[p].size() == 0) begin
                chk(p, "spurious_out_valid", 1, 0);
            end else begin
                e = q[p][0];
                if (!prev_ov[p]) chk(p, "latency", cyc - e.acc, beats[p]);
                chk(p, "sum", s, e.s);
                chk(p, "cout", co, e.c);
`ifdef SERIAL_ADDER_OVF_EN
                chk(p, "ovf", of, e.o);
`endif
                chk(p, "in_ready_busy", ir, 0);
                if (out_ready) begin
                    void'(q[p].pop_front());
                    prev_hs[p] = 1'b1;
                end
            end
        end
        prev_ov[p] = ov;
    endtask

    always @(negedge clk) begin
        if (timeouts != seen_to) begin
            chk(0, "out_valid_timeout", timeouts, seen_to);
            seen_to = timeouts;
        end
`ifdef SERIAL_ADDER_OVF_EN
        check_port(0, bus1.out_valid, bus1.in_ready, bus1.sum, bus1.cout, bus1.ovf);
        check_port(1, bus4.out_valid, bus4.in_ready, bus4.sum, bus4.cout, bus4.ovf);
`else
        check_port(0, bus1.out_valid, bus1.in_ready, bus1.sum, bus1.cout, 1'b0);
        check_port(1, bus4.out_valid, bus4.in_ready, bus4.sum, bus4.cout, 1'b0);
`endif
    end

    task automatic scramble_inputs();
        a   = W'($urandom);
        b   = W'($urandom);
        cin = 1'($urandom);
        sub = 1'($urandom);
    endtask

    // Entered and left at one time unit after a rising edge.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic icin, input logic isub);
        exp_t e;
        in_valid = 1'b1;
        a        = ia;
        b        = ib;
        cin      = icin;
        sub      = isub;
        e        = model(ia, ib, icin, isub);
        e.acc    = cyc + 1;
        q[0].push_back(e);
        q[1].push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble_inputs();
    endtask

    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic icin, input logic isub, input int hold);
        int n;
        issue(ia, ib, icin, isub);
        n = 0;
        while (!bus1.out_valid && n < 64) begin
            @(posedge clk); #1;
            scramble_inputs();
            n++;
        end
        if (!bus1.out_valid) timeouts++;
        // Extra offers while busy must be ignored.
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            scramble_inputs();
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(posedge clk); #1;
    endtask

    logic [W-1:0] da[8];
    logic [W-1:0] db[8];
    logic         dc[8];
    logic         ds[8];

    initial begin
        vectors     = 0;
        miscompares = 0;
        timeouts    = 0;
        seen_to     = 0;
        beats[0]    = 8;
        beats[1]    = 2;
        prev_ov     = '{1'b0, 1'b0};
        prev_hs     = '{1'b0, 1'b0};
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        a           = '0;
        b           = '0;
        cin         = 1'b0;
        sub         = 1'b0;
        da = '{8'h0F, 8'hFF, 8'h05, 8'h07, 8'hA5, 8'h7F, 8'h80, 8'h10};
        db = '{8'h01, 8'h01, 8'h07, 8'h05, 8'h5A, 8'h01, 8'h01, 8'h20};
        dc = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b0};
        ds = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0};

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run_op(da[i], db[i], dc[i], ds[i], (i == 0) ? 5 : i % 3);

        // Abort an operation mid-flight with an asynchronous reset.
        issue(8'h3C, 8'h11, 1'b1, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1 out_ready = 1'b0;

        for (int i = 0; i < 40; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3));
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_adder_dec.md
Name: serial_adder_dec

Overview:
- Multi-cycle, parametrised N-bit add/subtract unit built from chained decoder-based full-adder cells.
- Processes BPC bits per clock, LSB first, and keeps the carry in a flip-flop between cycles.
- Valid/ready handshake on both input and output.
- Successor to the single-bit combinational decoder full adder; used where area matters more than latency.

Parameters:
- WIDTH, 8, operand/result width in bits; must be ≥ 2.
- BPC, 1, bits processed per cycle (number of chained FA cells); must divide WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands/mode valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in; ignored when sub=1
- sub  input  1  0: A+B+cin; 1: A-B (computed as A+~B+1)
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result
- cout  output  1  final carry; in subtract mode 1 = no borrow

Behaviour:
- Reset values (asserted asynchronously): state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, internal shift registers/carry/counter=0.
- Clock and reset: one clock domain; reset is asynchronous and active-low.
- States: IDLE, RUN, DONE.
- in_ready=1 only in IDLE; out_valid=1 only in DONE.
- IDLE:
  - On in_valid&in_ready, latch a into shift reg SA.
  - Latch b into SB, or ~b when sub=1.
  - Initialise carry to cin, or to 1 when sub=1.
  - Clear beat counter; go to RUN.
- RUN, each cycle:
  - Low BPC bits of SA/SB feed BPC chained FA cells; carry register feeds cell 0.
  - SA/SB shift right by BPC.
  - The BPC sum bits are shifted into the top of the result register, so after the last beat the register holds sum LSB-aligned.
  - Carry register takes the last cell's carry-out; counter increments.
  - When counter reaches WIDTH/BPC-1 on a beat, that beat completes and state goes to DONE.
- Latency: out_valid rises exactly WIDTH/BPC clock edges after the accepting edge.
- DONE:
  - sum, cout and out_valid are held stable while out_ready=0 (unbounded backpressure).
  - On out_valid&out_ready, go to IDLE; in_ready=1 on the next cycle.
  - There is no same-cycle out→in bypass; minimum issue interval is WIDTH/BPC+2 cycles.
- in_valid in RUN/DONE is ignored; operands are not re-sampled.
- Input changes after acceptance have no effect on the result.
- sum/cout keep their last value in IDLE and RUN; they are only meaningful while out_valid=1.
- Reset mid-RUN or mid-DONE aborts the operation immediately: no out_valid pulse, all state cleared.
- Wrap-around: sum is modulo 2^WIDTH; the carry beyond WIDTH appears only on cout.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Extra output port ovf (1 bit), reset 0, valid with out_valid.
  - ovf = carry into MSB XOR carry out of MSB (two's-complement signed overflow), captured on the final beat.
  - Cell BPC-1 therefore also exports its carry-in.
- Undefined: port ovf absent; no extra logic.

Decomposition:
- Package serial_adder_pkg:
  - state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - function clog2 for counter width ($clog2(WIDTH/BPC), minimum 1).
- Sub-module fa_dec_cell:
  - one-bit full adder as an internal 3-to-8 one-hot decoder of {a,b,c};
  - sum = OR of minterms 1,2,4,7; carry = OR of minterms 3,5,6,7;
  - instantiated BPC times via generate.
- Top module holds FSM, counter, shift registers, carry FF.

Test Plan:
- WIDTH=8, BPC=1: a=0x0F, b=0x01, cin=0, sub=0 → after 8 cycles out_valid=1, sum=0x10, cout=0.
- WIDTH=8, BPC=1: a=0xFF, b=0x01, cin=1 → sum=0x01, cout=1. Then sub=1, a=0x05, b=0x07 → sum=0xFE, cout=0 (borrow); a=0x07, b=0x05 → sum=0x02, cout=1.
- WIDTH=8, BPC=4: a=0xA5, b=0x5A, cin=1 → out_valid exactly 2 edges after accept; sum=0x00, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → sum/cout/out_valid stable, in_ready=0, a second in_valid ignored; out_ready=1 → IDLE next cycle, in_ready=1.
- Reset: deassert rst_n asynchronously at beat 3 of an 8-beat op → in_ready=1, out_valid=0, sum=0, cout=0 immediately; no spurious result afterwards.
- With SERIAL_ADDER_OVF_EN: a=0x7F, b=0x01 → sum=0x80, ovf=1. sub=1, a=0x80, b=0x01 → sum=0x7F, ovf=1. a=0x10, b=0x20 → ovf=0.
